// File: rtl/led_chain_ctl_if.sv
// Pattern-load handshake between the raspi-side bridge and the LED sequencer.
// The bridge holds REQ_LOAD high and sees LOAD_ACK pulse once per request.
interface led_chain_ctl_if;
   logic        REQ_LOAD;
   logic [33:0] LOAD_DATA;
   logic        LOAD_ACK;

   modport master (
      output REQ_LOAD,
      output LOAD_DATA,
      input  LOAD_ACK
   );

   modport slave (
      input  REQ_LOAD,
      input  LOAD_DATA,
      output LOAD_ACK
   );
endinterface

// File: rtl/led_chain_ctl.sv
// Animation sequencer for the 34-LED GPIO chain plus on-board status LEDs.
// Prescaled steps run walk/bounce/fill/hold; handshake loads pre-empt steps.
module led_chain_ctl #(
   parameter int DIVBITS = 24
) (
   input  logic              FIFTYMHZ,
   input  logic              RESET,
   input  logic [1:0]        MODE,
   input  logic [2:0]        RATE_SEL,
   input  logic              PAUSE,
   led_chain_ctl_if.slave    ld,
   output logic [33:0]       GP0OUT,
   output logic [7:0]        LEDS,
   output logic              STEP
);

   typedef enum logic {HS_IDLE, HS_WAITDROP} hs_t;
   typedef enum logic [1:0] {M_WALK, M_BOUNCE, M_FILL, M_HOLD} mode_t;

   hs_t                hs_q, hs_d;
   mode_t              mode_q, mode_d;
   logic [DIVBITS-1:0] presc_q, presc_d;
   logic [DIVBITS-1:0] reload;
   logic [33:0]        gp_q, gp_d;
   logic [5:0]         pos_q, pos_d;
   logic               dir_q, dir_d;
   logic               wrap_q, wrap_d;
   logic               step_q, step_d;
   logic               ack_q, ack_d;
   logic               tick;
   logic               accept;

   // Ring position to chain bit: up the even side, down, then the odd side.
   function automatic logic [33:0] onehot(input logic [5:0] k);
      logic [5:0] b;
      if (k < 6'd8)
         b = (k << 2) + 6'd2;
      else if (k < 6'd17)
         b = 6'd32 - ((k - 6'd8) << 2);
      else if (k < 6'd25)
         b = ((k - 6'd17) << 2) + 6'd3;
      else
         b = 6'd33 - ((k - 6'd25) << 2);
      return 34'd1 << b;
   endfunction

   always_comb begin
      reload = '0;
      if ({29'd0, RATE_SEL} < 32'(DIVBITS))
         reload = {DIVBITS{1'b1}} >> RATE_SEL;
   end

   assign tick = (presc_q == '0) && !PAUSE;

   always_comb begin
      presc_d = presc_q;
      if (tick)
         presc_d = reload;
      else if (!PAUSE)
         presc_d = presc_q - DIVBITS'(1);
   end

   always_comb begin
      hs_d   = hs_q;
      mode_d = mode_q;
      gp_d   = gp_q;
      pos_d  = pos_q;
      dir_d  = dir_q;
      wrap_d = wrap_q;
      step_d = 1'b0;
      accept = (hs_q == HS_IDLE) && ld.REQ_LOAD;
      ack_d  = accept;

      unique case (hs_q)
         HS_IDLE:     if (ld.REQ_LOAD) hs_d = HS_WAITDROP;
         HS_WAITDROP: if (!ld.REQ_LOAD) hs_d = HS_IDLE;
      endcase

      // A load on a tick cycle swallows that tick entirely.
      if (accept) begin
         gp_d = ld.LOAD_DATA;
      end else if (tick) begin
         step_d = 1'b1;
         if (mode_t'(MODE) != mode_q) begin
            mode_d = mode_t'(MODE);
            gp_d   = '0;
            pos_d  = '0;
            dir_d  = 1'b0;
         end else begin
            unique case (mode_q)
               M_WALK: begin
                  gp_d = onehot(pos_q);
                  if (pos_q == 6'd33) begin
                     pos_d  = '0;
                     wrap_d = !wrap_q;
                  end else begin
                     pos_d = pos_q + 6'd1;
                  end
               end
               M_BOUNCE: begin
                  gp_d = onehot(pos_q);
                  if (!dir_q) begin
                     if (pos_q == 6'd33) begin
                        dir_d = 1'b1;
                        pos_d = 6'd32;
                     end else begin
                        pos_d = pos_q + 6'd1;
                     end
                  end else if (pos_q == 6'd0) begin
                     dir_d  = 1'b0;
                     pos_d  = 6'd1;
                     wrap_d = !wrap_q;
                  end else begin
                     pos_d = pos_q - 6'd1;
                  end
               end
               M_FILL: begin
                  if (pos_q < 6'd34) begin
                     gp_d  = gp_q | onehot(pos_q);
                     pos_d = pos_q + 6'd1;
                  end else begin
                     gp_d   = '0;
                     pos_d  = '0;
                     wrap_d = !wrap_q;
                  end
               end
               M_HOLD: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge FIFTYMHZ or posedge RESET) begin
      if (RESET) begin
         hs_q    <= HS_IDLE;
         mode_q  <= M_WALK;
         presc_q <= '0;
         gp_q    <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         wrap_q  <= 1'b0;
         step_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         hs_q    <= hs_d;
         mode_q  <= mode_d;
         presc_q <= presc_d;
         gp_q    <= gp_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         step_q  <= step_d;
         ack_q   <= ack_d;
      end
   end

   assign GP0OUT      = gp_q;
   assign LEDS        = {wrap_q, dir_q, pos_q};
   assign STEP        = step_q;
   assign ld.LOAD_ACK = ack_q;

endmodule

// File: tb/tb_led_chain_ctl.sv
// Directed bench for led_chain_ctl with DIVBITS=4 (16-clock steps).
// Expected LED patterns come from a hand-written ring table.
module tb_led_chain_ctl;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [2:0]  rate;
   logic        pause;
   logic [33:0] gp;
   logic [7:0]  leds;
   logic        step;

   int nchk = 0;
   int nerr = 0;
   int g;
   int nst;
   int nack;

   localparam int RING [34] = '{
      2, 6, 10, 14, 18, 22, 26, 30, 32, 28, 24, 20, 16, 12, 8, 4, 0,
      3, 7, 11, 15, 19, 23, 27, 31, 33, 29, 25, 21, 17, 13, 9, 5, 1
   };

   localparam logic [33:0] D1 = 34'h2_AAAA_AAAA;
   localparam logic [33:0] D2 = 34'h1_2345_6789;
   localparam logic [33:0] D3 = 34'h0_F0F0_0F0F;
   localparam logic [33:0] D4 = 34'h3_0000_0001;
   localparam logic [33:0] D5 = 34'h0_5555_5555;

   led_chain_ctl_if ldif ();

   led_chain_ctl #(.DIVBITS(4)) dut (
      .FIFTYMHZ (clk),
      .RESET    (rst),
      .MODE     (mode),
      .RATE_SEL (rate),
      .PAUSE    (pause),
      .ld       (ldif),
      .GP0OUT   (gp),
      .LEDS     (leds),
      .STEP     (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] bit_at(input int k);
      logic [63:0] one;
      one = 64'd1;
      return one << RING[k];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_step(output int gap);
      gap = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (step) begin
            gap = i;
            break;
         end
      end
      check("step_seen", 64'(gap != 0), 64'd1);
   endtask

   task automatic steps(input int n);
      int gg;
      for (int i = 0; i < n; i++) wait_step(gg);
   endtask

   initial begin
      rst = 1'b1;
      mode = 2'd0;
      rate = 3'd0;
      pause = 1'b0;
      ldif.REQ_LOAD = 1'b0;
      ldif.LOAD_DATA = '0;
      repeat (3) @(negedge clk);
      check("rst_gp", 64'(gp), 64'd0);
      check("rst_leds", 64'(leds), 64'd0);
      check("rst_ack", 64'(ldif.LOAD_ACK), 64'd0);
      check("rst_step", 64'(step), 64'd0);

      // WALK
      rst = 1'b0;
      wait_step(g);
      check("walk_first_gap", 64'(g), 64'd1);
      check("walk_s1", 64'(gp), bit_at(0));
      check("walk_s1_leds", 64'(leds), 64'h01);
      wait_step(g);
      check("walk_gap", 64'(g), 64'd16);
      check("walk_s2", 64'(gp), bit_at(1));
      wait_step(g);
      check("walk_s3", 64'(gp), bit_at(2));
      steps(31);
      check("walk_s34_leds", 64'(leds), 64'h80);
      steps(1);
      check("walk_s35", 64'(gp), bit_at(0));
      check("walk_s35_leds", 64'(leds), 64'h81);

      // BOUNCE
      mode = 2'd1;
      wait_step(g);
      check("bnc_restart_gp", 64'(gp), 64'd0);
      check("bnc_restart_leds", 64'(leds), 64'h80);
      steps(33);
      check("bnc_at33", 64'(gp), bit_at(32));
      check("bnc_at33_leds", 64'(leds), 64'hA1);
      steps(1);
      check("bnc_turn", 64'(gp), 64'd1 << 1);
      check("bnc_turn_leds", 64'(leds), 64'hE0);
      steps(32);
      check("bnc_at0", 64'(gp), bit_at(1));
      check("bnc_at0_leds", 64'(leds), 64'hC0);
      steps(1);
      check("bnc_wrap", 64'(gp), bit_at(0));
      check("bnc_wrap_leds", 64'(leds), 64'h01);

      // FILL
      mode = 2'd2;
      wait_step(g);
      check("fill_restart_gp", 64'(gp), 64'd0);
      check("fill_restart_leds", 64'(leds), 64'h00);
      steps(34);
      check("fill_full", 64'(gp), 64'h3_FFFF_FFFF);
      check("fill_full_leds", 64'(leds), 64'h22);
      steps(1);
      check("fill_wrap", 64'(gp), 64'd0);
      check("fill_wrap_leds", 64'(leds), 64'h80);

      // HOLD with loads
      mode = 2'd3;
      wait_step(g);
      check("hold_restart_leds", 64'(leds), 64'h80);
      ldif.REQ_LOAD = 1'b1;
      ldif.LOAD_DATA = D1;
      nack = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ldif.LOAD_ACK) nack++;
      end
      check("hold_ack1", 64'(nack), 64'd1);
      check("hold_load1", 64'(gp), 64'(D1));
      steps(2);
      check("hold_persist", 64'(gp), 64'(D1));
      check("hold_leds", 64'(leds), 64'h80);
      ldif.REQ_LOAD = 1'b0;
      repeat (2) @(negedge clk);
      ldif.REQ_LOAD = 1'b1;
      ldif.LOAD_DATA = D2;
      nack = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ldif.LOAD_ACK) nack++;
      end
      check("hold_ack2", 64'(nack), 64'd1);
      check("hold_load2", 64'(gp), 64'(D2));
      ldif.REQ_LOAD = 1'b0;

      // Load colliding with a WALK tick
      mode = 2'd0;
      wait_step(g);
      check("walk2_restart", 64'(gp), 64'd0);
      steps(2);
      check("walk2_s2", 64'(gp), bit_at(1));
      check("walk2_s2_leds", 64'(leds), 64'h82);
      repeat (15) @(negedge clk);
      ldif.REQ_LOAD = 1'b1;
      ldif.LOAD_DATA = D3;
      @(negedge clk);
      check("coll_step", 64'(step), 64'd0);
      check("coll_ack", 64'(ldif.LOAD_ACK), 64'd1);
      check("coll_gp", 64'(gp), 64'(D3));
      check("coll_leds", 64'(leds), 64'h82);
      ldif.REQ_LOAD = 1'b0;
      wait_step(g);
      check("coll_resume_gap", 64'(g), 64'd16);
      check("coll_resume_gp", 64'(gp), bit_at(2));
      check("coll_resume_leds", 64'(leds), 64'h83);

      // PAUSE, with a load accepted while paused
      pause = 1'b1;
      nst = 0;
      nack = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (step) nst++;
         if (ldif.LOAD_ACK) nack++;
         if (i == 40) begin
            ldif.REQ_LOAD = 1'b1;
            ldif.LOAD_DATA = D4;
         end
         if (i == 60) ldif.REQ_LOAD = 1'b0;
      end
      check("pause_nostep", 64'(nst), 64'd0);
      check("pause_ack", 64'(nack), 64'd1);
      check("pause_gp", 64'(gp), 64'(D4));
      pause = 1'b0;
      wait_step(g);
      check("unpause_gap", 64'(g), 64'd16);
      check("unpause_gp", 64'(gp), bit_at(3));
      check("unpause_leds", 64'(leds), 64'h84);

      // Reset while in WAITDROP, request still held
      ldif.REQ_LOAD = 1'b1;
      ldif.LOAD_DATA = D5;
      @(negedge clk);
      check("wd_ack", 64'(ldif.LOAD_ACK), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_gp", 64'(gp), 64'd0);
      check("mid_rst_leds", 64'(leds), 64'd0);
      check("mid_rst_ack", 64'(ldif.LOAD_ACK), 64'd0);
      check("mid_rst_step", 64'(step), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ack", 64'(ldif.LOAD_ACK), 64'd1);
      check("post_rst_step", 64'(step), 64'd0);
      check("post_rst_gp", 64'(gp), 64'(D5));
      ldif.REQ_LOAD = 1'b0;

      // RATE_SEL >= DIVBITS: step every clock
      rate = 3'd4;
      wait_step(g);
      check("fast_first", 64'(gp), bit_at(0));
      nst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (step) nst++;
      end
      check("fast_steps", 64'(nst), 64'd3);
      check("fast_gp", 64'(gp), bit_at(3));
      check("fast_leds", 64'(leds), 64'h04);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
